song_play_ctrl: RTL and testbench

//  Controller that sequences autoplay songs and arbitrates the single tone

---
 rtl/song_play_ctrl_pkg.sv | 32 +++
 rtl/song_play_ctrl_btn_sync_edge.sv | 22 ++
 rtl/song_play_ctrl.sv | 104 ++++++++++
 tb/tb_song_play_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_play_ctrl_pkg.sv
// Shared note encoding and the live/ROM source arbitration helper used by the
// song playback controller.
package song_play_ctrl_pkg;

  localparam int NOTE_W = 4;

  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

  // A held live key always wins; the song only sounds while actively playing.
  function automatic logic [NOTE_W-1:0] arb_note(
    input logic              key_valid,
    input logic [NOTE_W-1:0] key_note,
    input logic              song_active,
    input logic [NOTE_W-1:0] rom_note
  );
    if (key_valid)
      return key_note;
    else if (song_active)
      return rom_note;
    else
      return NOTE_NONE;
  endfunction

endpackage

// File: rtl/song_play_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous debounced button followed by a
// rising-edge detector producing a one-clock pulse.
module btn_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  output logic pulse
);

  // [0] metastable stage, [1] synchronised level, [2] previous synchronised level
  logic [2:0] sync_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      sync_reg <= 3'b000;
    else
      sync_reg <= {sync_reg[1:0], btn};
  end

  assign pulse = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/song_play_ctrl.sv
// Autoplay song sequencer: play/pause/stop FSM, beat-driven step counter and a
// registered mux sharing the tone generator between live keys and the song ROM.
module song_play_ctrl
  import song_play_ctrl_pkg::*;
#(
  parameter int STEP_W   = 6,
  parameter int SONG_LEN = 64,
  parameter int SEL_W    = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    beat_tick,
  input  logic                    btn_play,
  input  logic                    btn_stop,
  input  logic                    loop_en,
  input  logic [SEL_W-1:0]        song_sel,
  input  logic                    key_valid,
  input  logic [NOTE_W-1:0]       key_note,
  output logic [SEL_W+STEP_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0]       rom_note,
  output logic [NOTE_W-1:0]       note_out,
  output logic                    src_live,
  output logic                    playing,
  output logic                    song_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SONG_LEN - 1);

  state_t             state_reg;
  logic [STEP_W-1:0]  step_reg;
  logic [SEL_W-1:0]   song_reg;
  logic               play_p;
  logic               stop_p;

  btn_sync_edge u_play_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .btn   (btn_play),
    .pulse (play_p)
  );

  btn_sync_edge u_stop_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .btn   (btn_stop),
    .pulse (stop_p)
  );

  // Button events take priority over beat ticks; stop beats play.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      song_reg  <= '0;
      song_done <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (stop_p) begin
        state_reg <= IDLE;
        step_reg  <= '0;
      end else if (play_p) begin
        case (state_reg)
          IDLE: begin
            state_reg <= PLAY;
            step_reg  <= '0;
            song_reg  <= song_sel;
          end
          PLAY:    state_reg <= PAUSE;
          default: state_reg <= PLAY;
        endcase
      end else if (state_reg == PLAY && beat_tick) begin
        if (step_reg == LAST_STEP) begin
          song_done <= 1'b1;
          step_reg  <= '0;
          if (!loop_en)
            state_reg <= IDLE;
        end else begin
          step_reg <= step_reg + STEP_W'(1);
        end
      end
    end
  end

  // Live override only changes what is heard; the counter keeps running.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      note_out <= NOTE_NONE;
      src_live <= 1'b0;
    end else begin
      note_out <= arb_note(key_valid, key_note, state_reg == PLAY, rom_note);
      src_live <= key_valid;
    end
  end

  assign rom_addr = {song_reg, step_reg};
  assign playing  = (state_reg == PLAY);

endmodule

// File: tb/tb_song_play_ctrl.sv
// Randomised and directed bench for song_play_ctrl with a short 4-step song
// and a ROM whose note is step+1.
module tb_song_play_ctrl;

  localparam int STEP_W   = 2;
  localparam int SONG_LEN = 4;
  localparam int SEL_W    = 2;
  localparam int NOTE_W   = 4;

  logic                    CLK;
  logic                    RESET;
  logic                    beat_tick;
  logic                    btn_play;
  logic                    btn_stop;
  logic                    loop_en;
  logic [SEL_W-1:0]        song_sel;
  logic                    key_valid;
  logic [NOTE_W-1:0]       key_note;
  logic [SEL_W+STEP_W-1:0] rom_addr;
  logic [NOTE_W-1:0]       rom_note;
  logic [NOTE_W-1:0]       note_out;
  logic                    src_live;
  logic                    playing;
  logic                    song_done;

  int checks = 0;
  int errors = 0;

  song_play_ctrl #(
    .STEP_W   (STEP_W),
    .SONG_LEN (SONG_LEN),
    .SEL_W    (SEL_W)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .beat_tick (beat_tick),
    .btn_play  (btn_play),
    .btn_stop  (btn_stop),
    .loop_en   (loop_en),
    .song_sel  (song_sel),
    .key_valid (key_valid),
    .key_note  (key_note),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .note_out  (note_out),
    .src_live  (src_live),
    .playing   (playing),
    .song_done (song_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Song ROM: note is step+1 regardless of song.
  assign rom_note = NOTE_W'(rom_addr[STEP_W-1:0]) + 4'd1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 playing, 2 paused.
  int m_mode, m_step, m_song, m_note, m_live, m_done;
  bit [2:0] play_hist, stop_hist;
  bit press_play, press_stop;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_mode = 0; m_step = 0; m_song = 0; m_note = 0; m_live = 0; m_done = 0;
      play_hist = 3'b000; stop_hist = 3'b000;
    end else begin
      // A press is seen when the level sampled two edges ago is high and three edges ago low.
      press_play = play_hist[1] & ~play_hist[2];
      press_stop = stop_hist[1] & ~stop_hist[2];
      if (key_valid) begin
        m_note = int'(key_note); m_live = 1;
      end else begin
        m_note = (m_mode == 1) ? ((m_step + 1) % 16) : 0;
        m_live = 0;
      end
      m_done = 0;
      if (press_stop) begin
        m_mode = 0; m_step = 0;
      end else if (press_play) begin
        if (m_mode == 0) begin
          m_mode = 1; m_step = 0; m_song = int'(song_sel);
        end else if (m_mode == 1) begin
          m_mode = 2;
        end else begin
          m_mode = 1;
        end
      end else if (m_mode == 1 && beat_tick) begin
        if (m_step == SONG_LEN - 1) begin
          m_done = 1; m_step = 0;
          if (!loop_en) m_mode = 0;
        end else begin
          m_step = m_step + 1;
        end
      end
      play_hist = {play_hist[1:0], btn_play};
      stop_hist = {stop_hist[1:0], btn_stop};
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      check("rom_addr",  int'(rom_addr),  m_song * (1 << STEP_W) + m_step);
      check("note_out",  int'(note_out),  m_note);
      check("src_live",  int'(src_live),  m_live);
      check("playing",   int'(playing),   (m_mode == 1) ? 1 : 0);
      check("song_done", int'(song_done), m_done);
    end
  end

  task automatic clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press_play_btn();
    btn_play = 1'b1;
    clk(4);
    btn_play = 1'b0;
    clk(3);
  endtask

  task automatic tick();
    beat_tick = 1'b1;
    clk(1);
    beat_tick = 1'b0;
    clk(1);
  endtask

  initial begin
    RESET = 1'b1;
    beat_tick = 1'b0; btn_play = 1'b0; btn_stop = 1'b0; loop_en = 1'b0;
    song_sel = '0; key_valid = 1'b0; key_note = '0;
    clk(3);
    RESET = 1'b0;
    check("rst_note", int'(note_out), 0);
    check("rst_play", int'(playing), 0);
    check("rst_addr", int'(rom_addr), 0);
    check("rst_done", int'(song_done), 0);
    check("rst_live", int'(src_live), 0);

    // Single pass of song 2 without looping; later song_sel change ignored.
    song_sel = 2'd2;
    press_play_btn();
    check("s2_addr0", int'(rom_addr), 8);
    check("s2_note0", int'(note_out), 1);
    check("s2_play",  int'(playing), 1);
    song_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2_addr", int'(rom_addr), 9 + i);
      check("s2_note", int'(note_out), 2 + i);
    end
    beat_tick = 1'b1;
    clk(1);
    beat_tick = 1'b0;
    check("s2_done",   int'(song_done), 1);
    check("s2_idle",   int'(playing), 0);
    check("s2_addr_e", int'(rom_addr), 8);
    clk(1);
    check("s2_done_off", int'(song_done), 0);
    check("s2_note_e",   int'(note_out), 0);

    // Looping song 1 across a wrap.
    loop_en = 1'b1;
    song_sel = 2'd1;
    press_play_btn();
    repeat (6) tick();
    check("loop_addr", int'(rom_addr), 6);
    check("loop_play", int'(playing), 1);
    check("loop_note", int'(note_out), 3);

    btn_stop = 1'b1;
    clk(4);
    btn_stop = 1'b0;
    clk(3);
    check("stop_play", int'(playing), 0);
    check("stop_addr", int'(rom_addr), 4);

    // Pause holds the step through ticks, resume continues there.
    press_play_btn();
    tick();
    check("pz_addr1", int'(rom_addr), 5);
    press_play_btn();
    check("pz_play", int'(playing), 0);
    check("pz_note", int'(note_out), 0);
    repeat (3) tick();
    check("pz_hold", int'(rom_addr), 5);
    press_play_btn();
    check("pz_resume", int'(playing), 1);
    check("pz_addr2",  int'(rom_addr), 5);
    check("pz_note2",  int'(note_out), 2);

    // Live key overrides the note but not the stepping.
    key_valid = 1'b1;
    key_note = 4'd7;
    tick();
    tick();
    check("live_note", int'(note_out), 7);
    check("live_src",  int'(src_live), 1);
    check("live_addr", int'(rom_addr), 7);
    key_valid = 1'b0;
    clk(1);
    check("rel_note", int'(note_out), 4);
    check("rel_src",  int'(src_live), 0);

    // Simultaneous play and stop: stop wins.
    btn_play = 1'b1;
    btn_stop = 1'b1;
    clk(4);
    btn_play = 1'b0;
    btn_stop = 1'b0;
    clk(3);
    check("ps_play", int'(playing), 0);
    check("ps_addr", int'(rom_addr), 4);

    // Tick coinciding with the pause press is dropped.
    press_play_btn();
    tick();
    btn_play = 1'b1;
    clk(2);
    beat_tick = 1'b1;
    clk(1);
    beat_tick = 1'b0;
    check("tp_play", int'(playing), 0);
    check("tp_addr", int'(rom_addr), 5);
    btn_play = 1'b0;
    clk(3);

    // Asynchronous reset in the middle of a song.
    press_play_btn();
    tick();
    check("mr_addr", int'(rom_addr), 6);
    #2 RESET = 1'b1;
    #1;
    check("mr_note", int'(note_out), 0);
    check("mr_play", int'(playing), 0);
    check("mr_addr0", int'(rom_addr), 0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    clk(2);

    // Random traffic checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      beat_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) btn_play = ~btn_play;
      if ($urandom_range(0, 40) == 0) btn_stop = ~btn_stop;
      if ($urandom_range(0, 50) == 0) loop_en = ($urandom_range(0, 3) != 0);
      song_sel = SEL_W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) key_valid = ~key_valid;
      key_note = NOTE_W'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        #2 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
      end
      clk(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
